// File: rtl/tx_fc_pkg.sv
// tx_fc_pkg: credit typedefs, mod-2^W credit check and VC index width helper for tx_fc_multi_vc_gate
package tx_fc_pkg;
  localparam int PH_W_DEF = 8;
  localparam int PD_W_DEF = 12;
  localparam int NUM_VC_DEF = 2;
  typedef logic [PH_W_DEF-1:0] ph_credit_t;
  typedef logic [PD_W_DEF-1:0] pd_credit_t;
  function automatic int vc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int VC_IDX_W = vc_idx_w(NUM_VC_DEF);
  // Enough credit when the remaining headroom, taken mod 2^width, lies in the lower half of the ring
  function automatic logic credit_ok(input logic [31:0] limit, input logic [31:0] consumed,
                                     input logic [31:0] req, input int width);
    logic [31:0] mask;
    logic [31:0] half;
    mask = (32'h1 << width) - 32'h1;
    half = 32'h1 << (width - 1);
    return ((limit - consumed - req) & mask) <= half;
  endfunction
endpackage

// File: rtl/tx_fc_vc_fifo.sv
// tx_fc_vc_fifo: per-VC pending-TLP FIFO with show-ahead head; push is refused when full before any pop
module tx_fc_vc_fifo #(
  parameter int DW = 20,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign rd_data = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= wr_data;
endmodule

// File: rtl/tx_fc_multi_vc_gate.sv
// tx_fc_multi_vc_gate: per-VC FIFOs with PH/PD credit gating, RR arbiter and registered output; TX_FC_STALL_TIMEOUT_EN adds stall_err
module tx_fc_multi_vc_gate import tx_fc_pkg::*; #(
  parameter int NUM_VC = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PH_W = 8,
  parameter int PD_W = 12,
  parameter int PD_REQ_W = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VC-1:0]              wr_en,
  input  logic [NUM_VC*DATA_WIDTH-1:0]   wr_data,
  input  logic [NUM_VC*PD_REQ_W-1:0]     wr_pd,
  output logic [NUM_VC-1:0]              full,
  output logic [NUM_VC-1:0]              ovf_err,
  input  logic [NUM_VC-1:0]              cl_valid,
  input  logic [NUM_VC*PH_W-1:0]         ph_cl,
  input  logic [NUM_VC*PD_W-1:0]         pd_cl,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [vc_idx_w(NUM_VC)-1:0]    out_vc,
  output logic [NUM_VC*PH_W-1:0]         ph_cc,
  output logic [NUM_VC*PD_W-1:0]         pd_cc
`ifdef TX_FC_STALL_TIMEOUT_EN
  , output logic [NUM_VC-1:0]            stall_err
`endif
);
  localparam int VCW = vc_idx_w(NUM_VC);
  localparam int EW = DATA_WIDTH + PD_REQ_W;
  logic [NUM_VC-1:0] empty, elig, pop;
  logic [DATA_WIDTH-1:0] head_data [NUM_VC];
  logic [VCW-1:0] rr, gnt, idx;
  logic any, load;
  genvar v;
  generate
    for (v = 0; v < NUM_VC; v++) begin : g_vc
      logic [EW-1:0] head;
      logic [PD_REQ_W-1:0] head_pd;
      logic [PH_W-1:0] ph_cl_r, ph_cc_r;
      logic [PD_W-1:0] pd_cl_r, pd_cc_r;
      logic ovf;
      tx_fc_vc_fifo #(.DW(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk,
        .rst,
        .wr_en(wr_en[v]),
        .wr_data({wr_pd[v*PD_REQ_W +: PD_REQ_W], wr_data[v*DATA_WIDTH +: DATA_WIDTH]}),
        .rd_en(pop[v]),
        .rd_data(head),
        .empty(empty[v]),
        .full(full[v])
      );
      assign head_data[v] = head[DATA_WIDTH-1:0];
      assign head_pd = head[EW-1:DATA_WIDTH];
      assign elig[v] = !empty[v] && credit_ok(32'(ph_cl_r), 32'(ph_cc_r), 32'd1, PH_W) &&
                       (head_pd == '0 || credit_ok(32'(pd_cl_r), 32'(pd_cc_r), 32'(head_pd), PD_W));
      assign pop[v] = load && gnt == VCW'(v);
      assign ph_cc[v*PH_W +: PH_W] = ph_cc_r;
      assign pd_cc[v*PD_W +: PD_W] = pd_cc_r;
      assign ovf_err[v] = ovf;
      always_ff @(posedge clk) begin
        if (rst) begin
          ph_cl_r <= '0;
          pd_cl_r <= '0;
          ph_cc_r <= '0;
          pd_cc_r <= '0;
          ovf <= 1'b0;
        end else begin
          if (cl_valid[v]) begin
            ph_cl_r <= ph_cl[v*PH_W +: PH_W];
            pd_cl_r <= pd_cl[v*PD_W +: PD_W];
          end
          if (pop[v]) begin
            ph_cc_r <= ph_cc_r + PH_W'(1);
            pd_cc_r <= pd_cc_r + PD_W'(head_pd);
          end
          if (wr_en[v] && full[v]) ovf <= 1'b1;
        end
      end
`ifdef TX_FC_STALL_TIMEOUT_EN
      localparam int SW = $clog2(STALL_LIMIT + 1);
      logic [SW-1:0] stall_cnt;
      logic stall;
      assign stall_err[v] = stall;
      always_ff @(posedge clk) begin
        if (rst) begin
          stall_cnt <= '0;
          stall <= 1'b0;
        end else if (!empty[v] && !elig[v]) begin
          if (stall_cnt != SW'(STALL_LIMIT)) stall_cnt <= stall_cnt + SW'(1);
          if (stall_cnt == SW'(STALL_LIMIT - 1)) stall <= 1'b1;
        end else begin
          stall_cnt <= '0;
        end
      end
`endif
    end
  endgenerate
  // First eligible VC at or after the round-robin pointer
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = VCW'((int'(rr) + k) % NUM_VC);
      if (!any && elig[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  assign load = (!out_valid || out_ready) && any;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_vc <= '0;
      rr <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= head_data[gnt];
      out_vc <= gnt;
      rr <= VCW'((int'(gnt) + 1) % NUM_VC);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tx_fc_multi_vc_gate.sv
// tb_tx_fc_multi_vc_gate: table-driven vectors plus directed sequences for backpressure, credit wrap and overflow
module tb_tx_fc_multi_vc_gate;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] wr_en, full, ovf_err, cl_valid;
  logic [31:0] wr_data;
  logic [7:0] wr_pd;
  logic [15:0] ph_cl, ph_cc;
  logic [23:0] pd_cl, pd_cc;
  logic out_valid, out_ready;
  logic [15:0] out_data;
  logic [0:0] out_vc;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tx_fc_multi_vc_gate dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_pd(wr_pd), .full(full),
    .ovf_err(ovf_err), .cl_valid(cl_valid), .ph_cl(ph_cl), .pd_cl(pd_cl), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_vc(out_vc), .ph_cc(ph_cc), .pd_cc(pd_cc)
  );

  typedef struct {
    logic rst_b;
    logic [1:0] we;
    logic [15:0] d0, d1;
    logic [3:0] pd;
    logic [1:0] clv;
    logic [7:0] ph;
    logic [11:0] pdl;
    logic rdy;
    logic ev;
    logic evc;
    logic [15:0] ed;
    logic [7:0] eph;
    logic [11:0] epd;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic rst_b, input logic [1:0] we, input logic [15:0] d0, d1,
                              input logic [3:0] pd, input logic [1:0] clv, input logic [7:0] ph,
                              input logic [11:0] pdl, input logic rdy, input logic ev, input logic evc,
                              input logic [15:0] ed, input logic [7:0] eph, input logic [11:0] epd);
    vec_t r;
    r.rst_b = rst_b; r.we = we; r.d0 = d0; r.d1 = d1; r.pd = pd; r.clv = clv; r.ph = ph;
    r.pdl = pdl; r.rdy = rdy; r.ev = ev; r.evc = evc; r.ed = ed; r.eph = eph; r.epd = epd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [15:0] d0, d1, input logic [3:0] pd,
                       input logic [1:0] clv, input logic [7:0] ph, input logic [11:0] pdl,
                       input logic rdy);
    wr_en = we;
    wr_data = {d1, d0};
    wr_pd = {pd, pd};
    cl_valid = clv;
    ph_cl = {ph, ph};
    pd_cl = {pdl, pdl};
    out_ready = rdy;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // credit gating and re-credit on VC0
    tbl[0]  = mk(0, 2'b00, 16'h0000, 16'h0000, 2, 2'b01, 2, 4, 1, 0, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 2'b01, 16'h0201, 16'h0000, 2, 2'b00, 2, 4, 1, 0, 0, 16'h0000, 0, 0);
    tbl[2]  = mk(0, 2'b01, 16'h0202, 16'h0000, 2, 2'b00, 2, 4, 1, 1, 0, 16'h0201, 1, 2);
    tbl[3]  = mk(0, 2'b01, 16'h0203, 16'h0000, 2, 2'b00, 2, 4, 1, 1, 0, 16'h0202, 2, 4);
    tbl[4]  = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 0, 0, 16'h0000, 2, 4);
    tbl[5]  = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 0, 0, 16'h0000, 2, 4);
    tbl[6]  = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b01, 3, 6, 1, 0, 0, 16'h0000, 2, 4);
    tbl[7]  = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 1, 0, 16'h0203, 3, 6);
    tbl[8]  = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 0, 0, 16'h0000, 3, 6);
    // reset, then round-robin between two credited VCs
    tbl[9]  = mk(1, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 0, 0, 16'h0000, 0, 0);
    tbl[10] = mk(0, 2'b11, 16'h3000, 16'h3100, 1, 2'b11, 100, 100, 0, 0, 0, 16'h0000, 0, 0);
    tbl[11] = mk(0, 2'b11, 16'h3001, 16'h3101, 1, 2'b00, 0, 0, 0, 1, 0, 16'h3000, 1, 1);
    tbl[12] = mk(0, 2'b11, 16'h3002, 16'h3102, 1, 2'b00, 0, 0, 0, 1, 0, 16'h3000, 1, 1);
    tbl[13] = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 1, 1, 16'h3100, 1, 1);
    tbl[14] = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 1, 0, 16'h3001, 2, 2);
    tbl[15] = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 1, 1, 16'h3101, 2, 2);
    tbl[16] = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 1, 0, 16'h3002, 3, 3);
    tbl[17] = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 1, 1, 16'h3102, 3, 3);
    tbl[18] = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 1, 0, 0, 16'h0000, 3, 3);

    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    repeat (2) step;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_vc", 32'(out_vc), 0);
    chk("rst_ph_cc", 32'(ph_cc), 0);
    chk("rst_pd_cc", pd_cc, 0);
    rst = 1'b0;

    drive(2'b01, 16'h00A1, 0, 0, 2'b00, 0, 0, 1);
    step;
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    repeat (20) begin
      step;
      chk("no_credit_blocks", 32'(out_valid), 0);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst_b;
      drive(tbl[i].we, tbl[i].d0, tbl[i].d1, tbl[i].pd, tbl[i].clv, tbl[i].ph, tbl[i].pdl, tbl[i].rdy);
      step;
      rst = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_vc", i), 32'(out_vc), 32'(tbl[i].evc));
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      end
      chk($sformatf("v%0d_ph_cc0", i), 32'(ph_cc[7:0]), 32'(tbl[i].eph));
      chk($sformatf("v%0d_pd_cc0", i), 32'(pd_cc[11:0]), 32'(tbl[i].epd));
    end
    chk("ph_cc1_after_rr", 32'(ph_cc[15:8]), 3);
    chk("pd_cc1_after_rr", 32'(pd_cc[23:12]), 3);

    // backpressure holds the output and withholds consumption
    drive(2'b01, 16'h4444, 0, 1, 2'b00, 0, 0, 0);
    step;
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
    step;
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data", 32'(out_data), 32'h4444);
    chk("bp_ph_cc0", 32'(ph_cc[7:0]), 4);
    chk("bp_pd_cc0", 32'(pd_cc[11:0]), 4);
    repeat (5) begin
      step;
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 32'h4444);
      chk("bp_hold_ph_cc0", 32'(ph_cc[7:0]), 4);
      chk("bp_hold_pd_cc0", 32'(pd_cc[11:0]), 4);
    end
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    step;
    chk("bp_accept_valid", 32'(out_valid), 0);
    chk("bp_accept_ph_cc0", 32'(ph_cc[7:0]), 4);

    // walk ph_cc0 to 255, then wrap through 0 with ph_cl = 0
    drive(2'b00, 0, 0, 0, 2'b01, 128, 100, 1);
    step;
    for (int i = 0; i < 124; i++) begin
      drive(2'b01, 16'(i), 0, 0, 2'b00, 0, 0, 1);
      step;
    end
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    repeat (4) step;
    chk("walk_ph_cc0_128", 32'(ph_cc[7:0]), 128);
    drive(2'b00, 0, 0, 0, 2'b01, 255, 100, 1);
    step;
    for (int i = 0; i < 127; i++) begin
      drive(2'b01, 16'(i), 0, 0, 2'b00, 0, 0, 1);
      step;
    end
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    repeat (4) step;
    chk("walk_ph_cc0_255", 32'(ph_cc[7:0]), 255);
    chk("walk_valid_idle", 32'(out_valid), 0);
    drive(2'b00, 0, 0, 0, 2'b01, 0, 100, 1);
    step;
    drive(2'b01, 16'h5555, 0, 0, 2'b00, 0, 0, 1);
    step;
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    step;
    chk("wrap_valid", 32'(out_valid), 1);
    chk("wrap_data", 32'(out_data), 32'h5555);
    chk("wrap_ph_cc0", 32'(ph_cc[7:0]), 0);
    chk("wrap_pd_cc0", 32'(pd_cc[11:0]), 4);
    step;
    chk("wrap_drain", 32'(out_valid), 0);

    // VC1 starved of PH credit fills up; the ninth push overflows
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 0, 16'h6000 + 16'(i), 0, (i == 0) ? 2'b10 : 2'b00, 3, 100, 1);
      step;
    end
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    chk("fill_full", 32'(full), 32'b10);
    chk("fill_no_ovf", 32'(ovf_err), 0);
    chk("fill_blocked", 32'(out_valid), 0);
    drive(2'b10, 0, 16'h6008, 0, 2'b00, 0, 0, 1);
    step;
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    chk("ovf_set", 32'(ovf_err), 32'b10);
    chk("ovf_full", 32'(full), 32'b10);
    step;
    chk("ovf_sticky", 32'(ovf_err), 32'b10);
    chk("ovf_ph_cc1", 32'(ph_cc[15:8]), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
